// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit selector with manual select and round-robin auto-scan.
// Optional channel mask for the scan sequence is enabled with `define MUX_SCAN_MASK_EN.
module mux_scan_n #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned WIDTH  = 2,
  parameter int unsigned DWELL  = 4,
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    hold,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NUM_CH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]        data_out,
  output logic [SEL_W-1:0]        ch_out,
  output logic                    ch_stb
);

  localparam int unsigned CNT_W = $clog2(DWELL) + 1;

  localparam logic [0:0] ST_MAN  = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [SEL_W-1:0]  r_ch;
  logic [SEL_W-1:0]  w_ch_nxt;
  logic [SEL_W-1:0]  r_ch_prev;
  logic [WIDTH-1:0]  r_dout;
  logic [WIDTH-1:0]  w_dout_nxt;
  logic              r_stb;
  logic [NUM_CH-1:0] w_mask;
  logic              w_mask_none;
  logic [SEL_W-1:0]  w_ch_adv;
  logic [SEL_W-1:0]  w_hi;
  logic [SEL_W-1:0]  w_lo;
  logic              w_hi_found;
  logic              w_lo_found;

`ifdef MUX_SCAN_MASK_EN
  assign w_mask = ch_mask;
`else
  assign w_mask = '1;
`endif
  assign w_mask_none = ~|w_mask;

  // Out-of-range index yields zero so nothing undefined reaches data_out.
  function automatic logic [WIDTH-1:0] f_chan(input logic [NUM_CH*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (idx == SEL_W'(k)) v = d[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  // Next enabled channel above r_ch, else wrap to the lowest enabled one.
  always_comb begin
    w_hi       = '0;
    w_lo       = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int j = int'(NUM_CH) - 1; j >= 0; j--) begin
      if (w_mask[j]) begin
        if (SEL_W'(j) > r_ch) begin
          w_hi       = SEL_W'(j);
          w_hi_found = 1'b1;
        end
        w_lo       = SEL_W'(j);
        w_lo_found = 1'b1;
      end
    end
    if (w_hi_found)      w_ch_adv = w_hi;
    else if (w_lo_found) w_ch_adv = w_lo;
    else                 w_ch_adv = r_ch;
  end

  always_comb begin
    w_state_nxt = mode ? ST_SCAN : ST_MAN;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_dout_nxt  = r_dout;
    if (!hold) begin
      case (r_state)
        ST_SCAN: begin
          // A mode change to manual beats a dwell expiry in the same cycle.
          if (!mode) begin
            w_cnt_nxt  = '0;
            w_dout_nxt = w_mask_none ? '0 : f_chan(data_in, r_ch);
          end else if (r_cnt == CNT_W'(DWELL - 1)) begin
            w_cnt_nxt  = '0;
            w_ch_nxt   = w_ch_adv;
            w_dout_nxt = w_mask_none ? '0 : f_chan(data_in, w_ch_adv);
          end else begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            w_dout_nxt = w_mask_none ? '0 : f_chan(data_in, r_ch);
          end
        end
        default: begin
          w_cnt_nxt  = '0;
          w_ch_nxt   = sel;
          w_dout_nxt = f_chan(data_in, sel);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_MAN;
      r_cnt     <= '0;
      r_ch      <= '0;
      r_ch_prev <= '0;
      r_dout    <= '0;
      r_stb     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ch      <= w_ch_nxt;
      r_ch_prev <= r_ch;
      r_dout    <= w_dout_nxt;
      r_stb     <= (r_ch != r_ch_prev);
    end
  end

  assign data_out = r_dout;
  assign ch_out   = r_ch;
  assign ch_stb   = r_stb;

endmodule
